packet_serializer: RTL and testbench
====================================

PACKET_SERIALIZER -- requirements
Module: packet_serializer

Interface
REQ-001 The block SHALL have parameter DEST_ADDR_SIZE_X, default 4, meaning x destination field width.
REQ-002 The block SHALL have parameter DEST_ADDR_SIZE_Y, default 4, meaning y destination field width.
REQ-003 The block SHALL have parameter PAYLOAD_SIZE_BYTES, default 4, meaning maximum payload bytes per packet.
REQ-004 The block SHALL have parameter FLIT_W, default 16, meaning flit data width; a multiple of 8; FLIT_BYTES = FLIT_W/8.
REQ-005 The block SHALL define LEN_W = $clog2(PAYLOAD_SIZE_BYTES+1), and SHALL require FLIT_W >= DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + LEN_W.
REQ-006 The block SHALL have port clk, input, 1, the single clock.
REQ-007 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have port in_valid, input, 1, packet offered.
REQ-009 The block SHALL have port in_ready, output, 1, packet accepted when in_valid && in_ready.
REQ-010 The block SHALL have port in_x_dest, input, DEST_ADDR_SIZE_X, x destination.
REQ-011 The block SHALL have port in_y_dest, input, DEST_ADDR_SIZE_Y, y destination.
REQ-012 The block SHALL have port in_len, input, LEN_W, payload length in bytes, 0..PAYLOAD_SIZE_BYTES.
REQ-013 The block SHALL have port in_payload, input, 8*PAYLOAD_SIZE_BYTES, payload with byte 0 at bits [7:0].
REQ-014 The block SHALL have port out_valid, output, 1, flit present.
REQ-015 The block SHALL have port out_ready, input, 1, flit consumed when out_valid && out_ready.
REQ-016 The block SHALL have port out_data, output, FLIT_W, flit data.
REQ-017 The block SHALL have port out_type, output, 2, flit type: 00 HEAD, 01 BODY, 10 TAIL, 11 SINGLE.
REQ-018 The block SHALL have port len_err, output, 1, one-cycle pulse on acceptance of in_len > PAYLOAD_SIZE_BYTES.
REQ-019 The block SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, HEAD and BODY.
REQ-021 The block SHALL drive in_ready = 1 only in IDLE.
REQ-022 On acceptance, the block SHALL register destination, length and payload, and SHALL enter HEAD on the next edge.
REQ-023 An accepted in_len above PAYLOAD_SIZE_BYTES SHALL be saturated to PAYLOAD_SIZE_BYTES, and len_err SHALL pulse for the cycle after acceptance.
REQ-024 In HEAD, the block SHALL drive out_valid = 1 and out_data = zero-extended {x_dest, y_dest, len} with len in the LSBs.
REQ-025 In HEAD, out_type SHALL be SINGLE if len = 0, otherwise HEAD.
REQ-026 Head flit handshake: if len = 0, the block SHALL go to IDLE; otherwise it SHALL go to BODY with body index k = 0.
REQ-027 The body flit count SHALL be N = ceil(len/FLIT_BYTES).
REQ-028 Body flit k SHALL carry payload bytes k*FLIT_BYTES upward, byte-aligned from bit 0.
REQ-029 Bytes at or beyond len in a body flit SHALL be driven as zero.
REQ-030 Body flit k SHALL have out_type TAIL if k = N-1, otherwise BODY.
REQ-031 On each body handshake, k SHALL increment; on the TAIL handshake, the FSM SHALL go to IDLE.
REQ-032 While out_valid && !out_ready, out_data and out_type SHALL hold stable, and the FSM SHALL hold its state.
REQ-033 Latency SHALL be: head flit valid one cycle after acceptance.
REQ-034 Throughput SHALL be one flit per cycle under constant out_ready, with exactly one IDLE cycle between packets.
REQ-035 Input fields SHALL be ignored when in_valid && in_ready is false.

Reset
REQ-036 On rst_n low, the block SHALL asynchronously force IDLE, and in_ready SHALL be 1 during reset.
REQ-037 On rst_n low, the block SHALL asynchronously force out_valid = 0, out_data = 0, out_type = 00, len_err = 0, busy = 0 and k = 0.
REQ-038 On rst_n low, the block SHALL asynchronously clear the captured registers.
REQ-039 Reset asserted mid-packet SHALL discard the packet; no further flits of it SHALL appear after reset release.

Verification
REQ-040 Bench SHALL cover: x=3, y=5, len=4, payload 0xDDCCBBAA, out_ready=1 -> flits (HEAD, 0x01AC), (BODY, 0xBBAA), (TAIL, 0xDDCC) on consecutive cycles, head one cycle after acceptance.
REQ-041 Bench SHALL cover: len=3, same payload -> (HEAD, 0x01AB), (BODY, 0xBBAA), (TAIL, 0x00CC).
REQ-042 Bench SHALL cover: len=0 -> single flit (SINGLE, 0x01A8), then IDLE with in_ready=1.
REQ-043 Bench SHALL cover: len=7 -> len_err pulses once, head len field = 4, four payload bytes sent.
REQ-044 Bench SHALL cover: out_ready low for 3 cycles during a BODY flit -> out_data/out_type stable, no flit lost or duplicated, in_ready held 0.
REQ-045 Bench SHALL cover: rst_n pulsed low during BODY -> out_valid=0 immediately, in_ready=1, next packet serialised correctly.

Source files
------------

// File: rtl/packet_serializer.sv
// -----------------------------------------------------------------------------
// packet_serializer
//
// Purpose:
//   Accepts one packet per valid/ready handshake: a destination (x, y), a
//   payload length in bytes and a payload. It emits the packet as a stream of
//   flits on a valid/ready output. The first flit is the head flit, which
//   holds {x_dest, y_dest, len}, zero-extended, with len in the LSBs. The head
//   flit is followed by ceil(len / FLIT_BYTES) body flits. Each body flit
//   carries consecutive payload bytes starting at bit 0. Payload bytes at or
//   beyond len are driven as zero. A zero-length packet is a single flit.
//
// Ports:
//   clk        - single clock
//   rst_n      - asynchronous active-low reset
//   in_valid   - packet offered
//   in_ready   - high only while idle; packet accepted on in_valid && in_ready
//   in_x_dest  - x destination
//   in_y_dest  - y destination
//   in_len     - payload length in bytes (values above PAYLOAD_SIZE_BYTES
//                are saturated)
//   in_payload - payload, byte 0 at bits [7:0]
//   out_valid  - flit present
//   out_ready  - flit consumed on out_valid && out_ready
//   out_data   - flit data
//   out_type   - 00 HEAD, 01 BODY, 10 TAIL, 11 SINGLE
//   len_err    - one-cycle pulse after accepting an over-long in_len
//   busy       - high whenever a packet is being serialised
// -----------------------------------------------------------------------------
module packet_serializer #(
  parameter int  DEST_ADDR_SIZE_X   = 4,
  parameter int  DEST_ADDR_SIZE_Y   = 4,
  parameter int  PAYLOAD_SIZE_BYTES = 4,
  parameter int  FLIT_W             = 16,
  localparam int LEN_W              = $clog2(PAYLOAD_SIZE_BYTES + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DEST_ADDR_SIZE_X-1:0]     in_x_dest,
  input  logic [DEST_ADDR_SIZE_Y-1:0]     in_y_dest,
  input  logic [LEN_W-1:0]                in_len,
  input  logic [8*PAYLOAD_SIZE_BYTES-1:0] in_payload,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [FLIT_W-1:0]               out_data,
  output logic [1:0]                      out_type,
  output logic                            len_err,
  output logic                            busy
);

  localparam int FLIT_BYTES = FLIT_W / 8;
  localparam int PAY_W      = 8 * PAYLOAD_SIZE_BYTES;
  localparam int HDR_W      = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + LEN_W;
  localparam int NMAX       = (PAYLOAD_SIZE_BYTES + FLIT_BYTES - 1) / FLIT_BYTES;
  localparam int K_W        = (NMAX > 1) ? $clog2(NMAX) : 1;
  // Shift buffer wide enough that a full flit can always be sliced from it,
  // even when a flit is wider than the whole payload.
  localparam int SH_W       = (PAY_W > FLIT_W) ? PAY_W : FLIT_W;

  if ((FLIT_W % 8 != 0) || (FLIT_W < HDR_W)) begin : g_bad_params
    $error("packet_serializer: FLIT_W must be a multiple of 8 and hold x, y and len");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FT_HEAD   = 2'b00,
    FT_BODY   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  state_e                      state_q;
  logic [K_W-1:0]              k_q;
  logic [DEST_ADDR_SIZE_X-1:0] x_q, x_d;
  logic [DEST_ADDR_SIZE_Y-1:0] y_q, y_d;
  logic [LEN_W-1:0]            len_q, len_d;
  logic [PAY_W-1:0]            pay_q, pay_d;
  logic                        out_valid_q;
  logic [FLIT_W-1:0]           out_data_q;
  flit_type_e                  out_type_q;
  logic                        len_err_q;

  logic                        accept;
  logic                        len_over;
  logic [K_W-1:0]              k_inc;

  // Clamp over-long lengths to the payload capacity.
  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(PAYLOAD_SIZE_BYTES)) begin
      return LEN_W'(PAYLOAD_SIZE_BYTES);
    end
    return len;
  endfunction

  function automatic logic [FLIT_W-1:0] head_flit(
    input logic [DEST_ADDR_SIZE_X-1:0] x,
    input logic [DEST_ADDR_SIZE_Y-1:0] y,
    input logic [LEN_W-1:0]            len
  );
    logic [FLIT_W-1:0] f;
    f            = '0;
    f[HDR_W-1:0] = {x, y, len};
    return f;
  endfunction

  // Body flit k: payload bytes k*FLIT_BYTES upward, bytes at/after len zeroed.
  function automatic logic [FLIT_W-1:0] body_flit(
    input logic [PAY_W-1:0] pay,
    input logic [LEN_W-1:0] len,
    input logic [K_W-1:0]   k
  );
    logic [FLIT_W-1:0] f;
    logic [SH_W-1:0]   sh;
    f  = '0;
    sh = SH_W'(pay) >> (int'(k) * FLIT_W);
    for (int b = 0; b < FLIT_BYTES; b++) begin
      if ((int'(k) * FLIT_BYTES + b) < int'(len)) begin
        f[b*8 +: 8] = sh[b*8 +: 8];
      end
    end
    return f;
  endfunction

  // Flit k is the last one when it reaches or passes the final payload byte.
  function automatic logic is_last(input logic [LEN_W-1:0] len, input logic [K_W-1:0] k);
    return ((int'(k) + 1) * FLIT_BYTES) >= int'(len);
  endfunction

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid && in_ready;
  assign len_over  = (in_len > LEN_W'(PAYLOAD_SIZE_BYTES));
  assign k_inc     = k_q + 1'b1;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_type  = out_type_q;
  assign len_err   = len_err_q;

  // Capture registers load only on acceptance; inputs are ignored otherwise.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    len_d = len_q;
    pay_d = pay_q;
    if (accept) begin
      x_d   = in_x_dest;
      y_d   = in_y_dest;
      len_d = sat_len(in_len);
      pay_d = in_payload;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      len_q       <= '0;
      pay_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_type_q  <= FT_HEAD;
      len_err_q   <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      len_q     <= len_d;
      pay_q     <= pay_d;
      len_err_q <= accept && len_over;

      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= HEAD;
            out_valid_q <= 1'b1;
            out_data_q  <= head_flit(x_d, y_d, len_d);
            out_type_q  <= (len_d == '0) ? FT_SINGLE : FT_HEAD;
          end
        end

        HEAD: begin
          if (out_ready) begin
            if (len_q == '0) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              out_type_q  <= FT_HEAD;
            end else begin
              state_q    <= BODY;
              k_q        <= '0;
              out_data_q <= body_flit(pay_q, len_q, '0);
              out_type_q <= is_last(len_q, '0) ? FT_TAIL : FT_BODY;
            end
          end
        end

        BODY: begin
          if (out_ready) begin
            if (is_last(len_q, k_q)) begin
              state_q     <= IDLE;
              k_q         <= '0;
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              out_type_q  <= FT_HEAD;
            end else begin
              k_q        <= k_inc;
              out_data_q <= body_flit(pay_q, len_q, k_inc);
              out_type_q <= is_last(len_q, k_inc) ? FT_TAIL : FT_BODY;
            end
          end
        end

        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packet_serializer.sv
// -----------------------------------------------------------------------------
// tb_packet_serializer
//
// Directed bench for packet_serializer with default parameters (4-bit x/y,
// 4-byte payload, 16-bit flits). Expected flits are pushed to a queue as each
// packet is offered. A negedge monitor pops one entry per output handshake
// and compares it. Latency, idle gaps, len_err, backpressure and reset
// behaviour are checked inline in the stimulus sequence.
// -----------------------------------------------------------------------------
module tb_packet_serializer;

  localparam logic [1:0] T_HEAD   = 2'b00;
  localparam logic [1:0] T_BODY   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  typedef struct packed {
    logic [1:0]  t;
    logic [15:0] d;
  } flit_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_x_dest;
  logic [3:0]  in_y_dest;
  logic [2:0]  in_len;
  logic [31:0] in_payload;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_type;
  logic        len_err;
  logic        busy;

  flit_t exp_q[$];
  flit_t exp_f;
  flit_t got_f;
  int    checks = 0;
  int    errors = 0;

  packet_serializer #(
    .DEST_ADDR_SIZE_X  (4),
    .DEST_ADDR_SIZE_Y  (4),
    .PAYLOAD_SIZE_BYTES(4),
    .FLIT_W            (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x_dest (in_x_dest),
    .in_y_dest (in_y_dest),
    .in_len    (in_len),
    .in_payload(in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_type  (out_type),
    .len_err   (len_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output scoreboard: a flit seen valid+ready at negedge is consumed on the
  // next posedge (inputs only change just after posedges).
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL flit_unexpected got=%b/%h required=none", out_type, out_data);
      end
      if (exp_q.size() != 0) begin
        exp_f   = exp_q.pop_front();
        got_f.t = out_type;
        got_f.d = out_data;
        assert (got_f === exp_f) else begin
          errors++;
          $error("FAIL flit got=%b/%h required=%b/%h", got_f.t, got_f.d, exp_f.t, exp_f.d);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h required=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] t, input logic [15:0] d);
    flit_t f;
    f.t = t;
    f.d = d;
    exp_q.push_back(f);
  endtask

  task automatic scramble_inputs();
    in_x_dest  = 4'($urandom);
    in_y_dest  = 4'($urandom);
    in_len     = 3'($urandom);
    in_payload = $urandom;
  endtask

  // Called just after a posedge while the DUT is idle; returns just after
  // the accepting posedge with in_valid low and garbage on the fields.
  task automatic accept(input logic [3:0] x, input logic [3:0] y,
                        input logic [2:0] len, input logic [31:0] pay);
    in_valid   = 1'b1;
    in_x_dest  = x;
    in_y_dest  = y;
    in_len     = len;
    in_payload = pay;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble_inputs();
  endtask

  // Run a packet of n flits under out_ready=1: head one cycle after
  // acceptance, flits back to back, then idle.
  task automatic drain(input string tag, input int n, input logic [1:0] head_t,
                       input logic exp_err);
    @(negedge clk);
    chk({tag, "_head_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_head_type"}, 32'(out_type), 32'(head_t));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    chk({tag, "_len_err"}, 32'(len_err), 32'(exp_err));
    @(negedge clk);
    chk({tag, "_len_err_end"}, 32'(len_err), 32'd0);
    repeat (n - 1) @(negedge clk);
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    scramble_inputs();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_type", 32'(out_type), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // x=3 y=5 len=4 -> HEAD 01AC, BODY BBAA, TAIL DDCC
    push(T_HEAD, 16'h01AC); push(T_BODY, 16'hBBAA); push(T_TAIL, 16'hDDCC);
    accept(4'd3, 4'd5, 3'd4, 32'hDDCCBBAA);
    drain("len4", 3, T_HEAD, 1'b0);

    // len=3 -> last byte zero-filled
    push(T_HEAD, 16'h01AB); push(T_BODY, 16'hBBAA); push(T_TAIL, 16'h00CC);
    accept(4'd3, 4'd5, 3'd3, 32'hDDCCBBAA);
    drain("len3", 3, T_HEAD, 1'b0);

    // len=0 -> single flit
    push(T_SINGLE, 16'h01A8);
    accept(4'd3, 4'd5, 3'd0, 32'hDDCCBBAA);
    drain("len0", 1, T_SINGLE, 1'b0);

    // len=7 -> saturated to 4, len_err pulse
    push(T_HEAD, 16'h01AC); push(T_BODY, 16'h2211); push(T_TAIL, 16'h4433);
    accept(4'd3, 4'd5, 3'd7, 32'h44332211);
    drain("len7", 3, T_HEAD, 1'b1);

    // len=2 -> one body flit, directly TAIL
    push(T_HEAD, 16'h0782); push(T_TAIL, 16'h5AA5);
    accept(4'hF, 4'h0, 3'd2, 32'h12345AA5);
    drain("len2", 2, T_HEAD, 1'b0);

    // len=1 -> upper byte masked
    push(T_HEAD, 16'h0091); push(T_TAIL, 16'h0077);
    accept(4'd1, 4'd2, 3'd1, 32'hFFFFFF77);
    drain("len1", 2, T_HEAD, 1'b0);

    // Back to back with in_valid held: exactly one idle cycle between packets;
    // fields changed while busy must not disturb packet A.
    push(T_HEAD, 16'h010C); push(T_BODY, 16'h4321); push(T_TAIL, 16'h8765);
    push(T_HEAD, 16'h023B); push(T_BODY, 16'h8877); push(T_TAIL, 16'h0099);
    in_valid   = 1'b1;
    in_x_dest  = 4'd2;
    in_y_dest  = 4'd1;
    in_len     = 3'd4;
    in_payload = 32'h87654321;
    @(posedge clk);
    #1;
    in_x_dest  = 4'd4;
    in_y_dest  = 4'd7;
    in_len     = 3'd3;
    in_payload = 32'hAA998877;
    @(negedge clk);
    chk("b2b_a_head_valid", 32'(out_valid), 32'd1);
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("b2b_gap_out_valid", 32'(out_valid), 32'd0);
    chk("b2b_gap_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble_inputs();
    drain("b2b_b", 3, T_HEAD, 1'b0);

    // Backpressure: out_ready low for 3 cycles during a BODY flit
    push(T_HEAD, 16'h01AC); push(T_BODY, 16'hBBAA); push(T_TAIL, 16'hDDCC);
    accept(4'd3, 4'd5, 3'd4, 32'hDDCCBBAA);
    @(negedge clk);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_type", 32'(out_type), 32'(T_BODY));
      chk("bp_out_data", 32'(out_data), 32'h0000BBAA);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
    chk("bp_idle_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Reset during BODY: packet discarded, next packet clean
    push(T_HEAD, 16'h01AC); push(T_BODY, 16'hBBAA); push(T_TAIL, 16'hDDCC);
    accept(4'd3, 4'd5, 3'd4, 32'hDDCCBBAA);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("mrst_pre_body_type", 32'(out_type), 32'(T_BODY));
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_out_data", 32'(out_data), 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mrst_no_stale_flit", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    push(T_HEAD, 16'h01AB); push(T_BODY, 16'hBBAA); push(T_TAIL, 16'h00CC);
    accept(4'd3, 4'd5, 3'd3, 32'hDDCCBBAA);
    drain("post_rst", 3, T_HEAD, 1'b0);

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
